// File: rtl/divu_multicycle.sv
// rtl/divu_multicycle.sv - sequential unsigned divider (DIVU) for the EX stage
//
// Purpose:
//   Restoring shift-subtract divider. Resolves one quotient bit per clock.
//   Quotient is the LO result and remainder is the HI result.
//   Latency from accept to done is WIDTH cycles.
//
// Optional feature macro:
//   DIVU_FAST_ZERO_EN : a zero divisor seen at accept skips the iterations,
//                       and done pulses one cycle after accept.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, qualified by SignalIn == DIVU (4'b0100)
//   SignalIn   in   [3:0] ALU control code of the issuing instruction
//   flush      in   synchronous pipeline cancel
//   inputA     in   [WIDTH-1:0] dividend
//   inputB     in   [WIDTH-1:0] divisor
//   busy       out  division in progress
//   done       out  one-cycle pulse, results valid
//   quotient   out  [WIDTH-1:0] LO result, held until the next done
//   remainder  out  [WIDTH-1:0] HI result, held until the next done
//   divByZero  out  divisor was zero, held with the results

module divu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       SignalIn,
    input  logic             flush,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int         CW       = $clog2(WIDTH + 1);
    localparam logic [3:0] ALU_DIVU = 4'b0100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;        // partial remainder
    logic [WIDTH-1:0] r_quo;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_divisor;
    logic             r_div_zero;
    logic             r_fast;       // zero-divisor shortcut in flight

    logic             w_accept;
    logic             w_fast_zero;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH:0]   w_next_rem;
    logic [WIDTH-1:0] w_next_quo;

    assign w_accept = start & (SignalIn == ALU_DIVU) & ~flush;

`ifdef DIVU_FAST_ZERO_EN
    assign w_fast_zero = (inputB == '0);
`else
    assign w_fast_zero = 1'b0;
`endif

    // One restoring step. The borrow is the MSB of the extended difference,
    // the same rule the ALU subtract path uses.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {2'b00, r_divisor};
    assign w_borrow   = w_trial[WIDTH+1];
    assign w_next_rem = w_borrow ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
    assign w_next_quo = {r_quo[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_div_zero <= 1'b0;
            r_fast     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            divByZero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quo      <= inputA;
                        r_divisor  <= inputB;
                        r_rem      <= '0;
                        r_div_zero <= (inputB == '0);
                        r_fast     <= w_fast_zero;
                        r_cnt      <= w_fast_zero ? CW'(1) : CW'(WIDTH);
                        busy       <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        // Cancel: results and flag keep the previous division.
                        busy    <= 1'b0;
                        r_fast  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_next_rem;
                        r_quo <= w_next_quo;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            r_fast    <= 1'b0;
                            r_state   <= S_IDLE;
                            divByZero <= r_div_zero;
                            // In the shortcut, r_quo still holds the untouched dividend.
                            quotient  <= r_fast ? '1    : w_next_quo;
                            remainder <= r_fast ? r_quo : w_next_rem[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_multicycle.sv
// tb/tb_divu_multicycle.sv - self-checking bench for divu_multicycle

module tb_divu_multicycle;

    localparam int         WIDTH = 32;
    localparam logic [3:0] DIVU  = 4'b0100;
`ifdef DIVU_FAST_ZERO_EN
    localparam int         ZLAT  = 1;
`else
    localparam int         ZLAT  = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       SignalIn;
    logic             flush;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    divu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .SignalIn  (SignalIn),
        .flush     (flush),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          chain;   // next vector is issued in this vector's done cycle
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sig);
        @(negedge clk);
        inputA   = a;
        inputB   = b;
        SignalIn = sig;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after an accept edge; returns at the negedge of the done cycle.
    task automatic wait_done(output int lat, output int bcnt, output bit seen);
        lat  = 0;
        bcnt = 0;
        seen = 0;
        while (lat <= WIDTH + 8) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic quiet_window(input string name, input int n);
        int hits;
        hits = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy || done) hits++;
        end
        chk(name, hits, 0);
    endtask

    initial begin
        int  lat;
        int  bcnt;
        bit  seen;
        bit  chained;
        logic [31:0] cq, cr;
        logic        cz;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0, WIDTH, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, WIDTH, 1'b1};
        vecs[2] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,    1'b0, WIDTH, 1'b0};
        vecs[3] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1, ZLAT,  1'b0};
        vecs[4] = '{32'd30,         32'd4,          32'd7,          32'd2,    1'b0, WIDTH, 1'b0};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0, WIDTH, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0, WIDTH, 1'b0};
        vecs[7] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,    1'b0, WIDTH, 1'b0};
        vecs[8] = '{32'h1234_5678,  32'h100,        32'h0012_3456,  32'h78,   1'b0, WIDTH, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        SignalIn = 4'b0000;
        inputA   = '0;
        inputB   = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_divbyzero", divByZero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        chained = 0;
        for (int i = 0; i < 9; i++) begin
            if (!chained) issue(vecs[i].a, vecs[i].b, DIVU);
            wait_done(lat, bcnt, seen);
            cq = quotient;
            cr = remainder;
            cz = divByZero;
            chained = 0;
            if (vecs[i].chain && seen) begin
                inputA   = vecs[i+1].a;
                inputB   = vecs[i+1].b;
                SignalIn = DIVU;
                start    = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                chained = 1;
            end
            chk($sformatf("v%0d_done_seen", i), seen, 1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
            chk($sformatf("v%0d_quotient", i), cq, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), cr, vecs[i].r);
            chk($sformatf("v%0d_divbyzero", i), cz, vecs[i].z);
        end

        // Wrong control code: ignored entirely.
        issue(32'd9, 32'd3, 4'b0110);
        quiet_window("wrong_sig_idle", 40);
        chk("wrong_sig_quotient_held", quotient, 32'h0012_3456);

        // Start pulsed while busy must not disturb the in-flight division.
        issue(32'd100, 32'd7, DIVU);
        repeat (5) @(posedge clk);
        @(negedge clk);
        inputA = 32'd50;
        inputB = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt, seen);
        chk("busy_start_seen", seen, 1);
        chk("busy_start_quotient", quotient, 14);
        chk("busy_start_remainder", remainder, 2);

        // Flush at iteration 10 of 30/4.
        issue(32'd30, 32'd4, DIVU);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        quiet_window("flush_idle", 40);
        chk("flush_quotient_held", quotient, 14);
        chk("flush_remainder_held", remainder, 2);
        chk("flush_divbyzero_held", divByZero, 0);

        // Flush coinciding with start drops the request.
        @(negedge clk);
        inputA   = 32'd30;
        inputB   = 32'd4;
        SignalIn = DIVU;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1 begin
            start = 1'b0;
            flush = 1'b0;
        end
        quiet_window("flush_start_dropped", 40);

        issue(32'd30, 32'd4, DIVU);
        wait_done(lat, bcnt, seen);
        chk("post_flush_latency", lat, WIDTH);
        chk("post_flush_quotient", quotient, 7);
        chk("post_flush_remainder", remainder, 2);

        // Asynchronous reset mid-operation.
        issue(32'd1000, 32'd3, DIVU);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_quotient", quotient, 0);
        chk("async_rst_remainder", remainder, 0);
        chk("async_rst_divbyzero", divByZero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("post_reset_idle", 45);

        chk("busy_done_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
